// File: rtl/ram_window_ctrl_if.sv
// Z80-side bus and SRAM-side control bundle for the 0xB800-0xFFFF RAM window controller.
// The Z80 strobes are active-low and asynchronous: a transfer is requested while MREQ_N
// is low with exactly one of RD_N/WR_N low, and WAIT_N low asks the CPU to stretch it.
interface ram_window_ctrl_if;
  logic [4:0] Addr;
  logic [7:0] PortAddr;
  logic [7:0] D;
  logic       MREQ_N;
  logic       IORQ_N;
  logic       RD_N;
  logic       WR_N;
  logic       RAM_CS_N;
  logic       RAM_OE_N;
  logic       RAM_WE_N;
  logic [1:0] RAM_BA;
  logic       WAIT_N;
  logic [7:0] CTRL;

  modport master (
    output Addr, PortAddr, D, MREQ_N, IORQ_N, RD_N, WR_N,
    input  RAM_CS_N, RAM_OE_N, RAM_WE_N, RAM_BA, WAIT_N, CTRL
  );

  modport slave (
    input  Addr, PortAddr, D, MREQ_N, IORQ_N, RD_N, WR_N,
    output RAM_CS_N, RAM_OE_N, RAM_WE_N, RAM_BA, WAIT_N, CTRL
  );
endinterface

// File: rtl/ram_window_ctrl.sv
// Banked SRAM window controller for a Z80: synchronizes the strobes, decodes the window,
// inserts programmable wait states and drives registered SRAM controls.
module ram_window_ctrl (
  input  logic               CLK,
  input  logic               RESET,
  ram_window_ctrl_if.slave   bus,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAITST  = 2'd1,
    S_ACTIVE  = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t     r_state;
  logic       r_mreq_s1, r_mreq_s2;
  logic       r_iorq_s1, r_iorq_s2;
  logic       r_rd_s1, r_rd_s2;
  logic       r_wr_s1, r_wr_s2;
  logic       r_iorq_prev;
  logic [7:0] r_ctrl;
  logic [1:0] r_cnt;
  logic       r_dir_wr;
  logic       r_wp;
  logic       r_cs_n, r_oe_n, r_we_n, r_wait_n;
  logic [1:0] r_ba;

  logic       w_ctrl_ld;
  logic [7:0] w_ctrl_nxt;
  logic       w_hit;
  logic       w_start;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_mreq_s1   <= 1'b1;
      r_mreq_s2   <= 1'b1;
      r_iorq_s1   <= 1'b1;
      r_iorq_s2   <= 1'b1;
      r_rd_s1     <= 1'b1;
      r_rd_s2     <= 1'b1;
      r_wr_s1     <= 1'b1;
      r_wr_s2     <= 1'b1;
      r_iorq_prev <= 1'b1;
    end else begin
      r_mreq_s1   <= bus.MREQ_N;
      r_mreq_s2   <= r_mreq_s1;
      r_iorq_s1   <= bus.IORQ_N;
      r_iorq_s2   <= r_iorq_s1;
      r_rd_s1     <= bus.RD_N;
      r_rd_s2     <= r_rd_s1;
      r_wr_s1     <= bus.WR_N;
      r_wr_s2     <= r_wr_s1;
      r_iorq_prev <= r_iorq_s2;
    end
  end

  // Load only on the falling edge of synced IORQ_N so one I/O cycle writes CTRL once.
  assign w_ctrl_ld  = !r_iorq_s2 && !r_wr_s2 && r_iorq_prev && (bus.PortAddr == 8'h7F);
  assign w_ctrl_nxt = w_ctrl_ld ? (bus.D & 8'h9F) : r_ctrl;
  assign w_hit      = (bus.Addr >= 5'b10111);
  assign w_start    = !r_mreq_s2 && (r_rd_s2 ^ r_wr_s2) && w_hit && r_ctrl[7];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ctrl <= 8'h80;
    end else begin
      r_ctrl <= w_ctrl_nxt;
    end
  end

  // Bank, direction, WP and wait count are captured at cycle start so later CTRL or
  // bus changes only affect the next RAM cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= 2'd0;
      r_dir_wr <= 1'b0;
      r_wp     <= 1'b0;
      r_cs_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_wait_n <= 1'b1;
      r_ba     <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ba <= w_ctrl_nxt[1:0];
          if (w_start) begin
            r_state  <= S_WAITST;
            r_dir_wr <= !r_wr_s2;
            r_wp     <= r_ctrl[2];
            r_cnt    <= r_ctrl[4:3];
            r_wait_n <= (r_ctrl[4:3] == 2'd0);
            r_ba     <= r_ctrl[1:0];
          end
        end
        S_WAITST: begin
          if (r_mreq_s2) begin
            r_state  <= S_RECOVER;
            r_wait_n <= 1'b1;
            r_ba     <= w_ctrl_nxt[1:0];
          end else if (r_cnt != 2'd0) begin
            r_cnt    <= r_cnt - 2'd1;
            r_wait_n <= (r_cnt == 2'd1);
          end else begin
            r_state <= S_ACTIVE;
            r_cs_n  <= 1'b0;
            r_oe_n  <= r_dir_wr;
            r_we_n  <= !(r_dir_wr && !r_wp);
          end
        end
        S_ACTIVE: begin
          if (r_mreq_s2) begin
            r_state <= S_RECOVER;
            r_cs_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_ba    <= w_ctrl_nxt[1:0];
          end
        end
        S_RECOVER: begin
          r_state <= S_IDLE;
          r_ba    <= w_ctrl_nxt[1:0];
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.RAM_CS_N = r_cs_n;
  assign bus.RAM_OE_N = r_oe_n;
  assign bus.RAM_WE_N = r_we_n;
  assign bus.RAM_BA   = r_ba;
  assign bus.WAIT_N   = r_wait_n;
  assign bus.CTRL     = r_ctrl;
  assign o_state      = r_state;

endmodule

// File: tb/tb_ram_window_ctrl.sv
// Directed bench for ram_window_ctrl: a table of memory-cycle vectors plus hand-written
// sequences for mid-cycle bus changes, aborted wait states and reset during WAITST.
module tb_ram_window_ctrl;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];

  ram_window_ctrl_if bus();

  ram_window_ctrl dut (
    .CLK     (clk),
    .RESET   (rst),
    .bus     (bus.slave),
    .o_state (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] ctrl_d;
    logic [7:0] exp_ctrl;
    logic [4:0] addr;
    logic       mreq_n;
    logic       rd_n;
    logic       wr_n;
    logic       exp_hit;
    int         exp_lat;
    int         exp_waits;
    logic       exp_oe_n;
    logic       exp_we_n;
    logic [1:0] exp_ba;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.MREQ_N = 1'b1;
    bus.IORQ_N = 1'b1;
    bus.RD_N   = 1'b1;
    bus.WR_N   = 1'b1;
  endtask

  task automatic io_write(input logic [7:0] d);
    @(negedge clk);
    bus.PortAddr = 8'h7F;
    bus.D        = d;
    bus.IORQ_N   = 1'b0;
    bus.WR_N     = 1'b0;
    repeat (4) @(negedge clk);
    bus.IORQ_N = 1'b1;
    bus.WR_N   = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic start_cycle(input logic [4:0] addr, input logic mreq_n, input logic rd_n,
                             input logic wr_n);
    bus.Addr   = addr;
    bus.MREQ_N = mreq_n;
    bus.RD_N   = rd_n;
    bus.WR_N   = wr_n;
  endtask

  task automatic release_and_idle(input string name);
    bit done;
    @(negedge clk);
    bus_idle();
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(posedge clk);
      #1;
      if (state_dbg == ST_IDLE && bus.RAM_CS_N) done = 1'b1;
    end
    check({name, " idle_after_release"}, done, 1'b1);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int   lat, waits;
    logic any_low;
    logic oe_n, we_n;
    logic [1:0] ba;
    io_write(v.ctrl_d);
    exp_q.push_back(v.exp_ctrl);
    check({v.name, " ctrl"}, bus.CTRL, exp_q.pop_front());
    start_cycle(v.addr, v.mreq_n, v.rd_n, v.wr_n);
    lat = 0; waits = 0; any_low = 1'b0;
    oe_n = 1'b1; we_n = 1'b1; ba = 2'd0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (!bus.RAM_CS_N && lat == 0) begin
        lat  = k;
        oe_n = bus.RAM_OE_N;
        we_n = bus.RAM_WE_N;
        ba   = bus.RAM_BA;
      end
      if (!bus.WAIT_N) waits++;
      if (!bus.RAM_CS_N || !bus.RAM_OE_N || !bus.RAM_WE_N) any_low = 1'b1;
      check({v.name, " oe_we_excl"},
            !(!bus.RAM_OE_N && !bus.RAM_WE_N) &&
            !((!bus.RAM_OE_N || !bus.RAM_WE_N) && bus.RAM_CS_N), 1'b1);
    end
    check({v.name, " waits"}, waits, v.exp_waits);
    if (v.exp_hit) begin
      check({v.name, " latency"}, lat, v.exp_lat);
      check({v.name, " oe_n"}, oe_n, v.exp_oe_n);
      check({v.name, " we_n"}, we_n, v.exp_we_n);
      check({v.name, " ba"}, ba, v.exp_ba);
    end else begin
      check({v.name, " ram_quiet"}, any_low, 1'b0);
    end
    release_and_idle(v.name);
  endtask

  initial begin
    bit   found;
    int   rec_cnt, rec_at;
    logic cs_seen;

    vecs[0]  = '{"rd_b800",      8'h80, 8'h80, 5'b10111, 1'b0, 1'b0, 1'b1, 1'b1, 4, 0, 1'b0, 1'b1, 2'b00};
    vecs[1]  = '{"rd_miss",      8'h80, 8'h80, 5'b10110, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 2'b00};
    vecs[2]  = '{"no_strobe",    8'h80, 8'h80, 5'b10111, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 2'b00};
    vecs[3]  = '{"both_strobe",  8'h80, 8'h80, 5'b10111, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 2'b00};
    vecs[4]  = '{"wr_wp_ws3",    8'h9E, 8'h9E, 5'b11111, 1'b0, 1'b1, 1'b0, 1'b1, 7, 3, 1'b1, 1'b1, 2'b10};
    vecs[5]  = '{"wr_bank1",     8'h81, 8'h81, 5'b11000, 1'b0, 1'b1, 1'b0, 1'b1, 4, 0, 1'b1, 1'b0, 2'b01};
    vecs[6]  = '{"rd_rsvd_mask", 8'hFF, 8'h9F, 5'b11100, 1'b0, 1'b0, 1'b1, 1'b1, 7, 3, 1'b0, 1'b1, 2'b11};
    vecs[7]  = '{"en_off",       8'h0B, 8'h0B, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 2'b00};
    vecs[8]  = '{"rd_ws1_wp",    8'h8D, 8'h8D, 5'b10111, 1'b0, 1'b0, 1'b1, 1'b1, 5, 1, 1'b0, 1'b1, 2'b01};
    vecs[9]  = '{"wr_ws1",       8'hA8, 8'h88, 5'b11110, 1'b0, 1'b1, 1'b0, 1'b1, 5, 1, 1'b1, 1'b0, 2'b00};
    vecs[10] = '{"mreq_high",    8'h80, 8'h80, 5'b10111, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 2'b00};

    // clock/reset
    bus_idle();
    bus.Addr     = 5'd0;
    bus.PortAddr = 8'h00;
    bus.D        = 8'h00;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("rst cs_n", bus.RAM_CS_N, 1'b1);
    check("rst oe_n", bus.RAM_OE_N, 1'b1);
    check("rst we_n", bus.RAM_WE_N, 1'b1);
    check("rst wait_n", bus.WAIT_N, 1'b1);
    check("rst ba", bus.RAM_BA, 2'b00);
    check("rst ctrl", bus.CTRL, 8'h80);
    check("rst state", state_dbg, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Bus and CTRL changes while ACTIVE must not disturb the cycle; new bank shows after it.
    io_write(8'h81);
    start_cycle(5'b11111, 1'b0, 1'b0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk);
      #1;
      if (!bus.RAM_CS_N) found = 1'b1;
    end
    check("act reached", found, 1'b1);
    @(negedge clk);
    bus.Addr = 5'b00111;
    bus.RD_N = 1'b1;
    io_write(8'h82);
    check("act ctrl_new", bus.CTRL, 8'h82);
    check("act cs_n", bus.RAM_CS_N, 1'b0);
    check("act oe_n", bus.RAM_OE_N, 1'b0);
    check("act we_n", bus.RAM_WE_N, 1'b1);
    check("act ba_latched", bus.RAM_BA, 2'b01);
    check("act state", state_dbg, ST_ACTIVE);
    bus.MREQ_N = 1'b1;
    rec_cnt = 0; rec_at = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (state_dbg == ST_RECOVER) begin
        rec_cnt++;
        rec_at = k;
        check("rec outputs_high", {bus.RAM_CS_N, bus.RAM_OE_N, bus.RAM_WE_N}, 3'b111);
      end
    end
    check("rec count", rec_cnt, 1);
    check("rec at_edge", rec_at, 3);
    check("rec idle", state_dbg, ST_IDLE);
    check("rec ba_ctrl", bus.RAM_BA, 2'b10);
    release_and_idle("act");

    // MREQ_N released during WAITST: straight to RECOVER, CS never asserted.
    io_write(8'h98);
    start_cycle(5'b11000, 1'b0, 1'b0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk);
      #1;
      if (!bus.WAIT_N) found = 1'b1;
    end
    check("abort wait_seen", found, 1'b1);
    @(negedge clk);
    bus.MREQ_N = 1'b1;
    cs_seen = 1'b0; rec_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (!bus.RAM_CS_N) cs_seen = 1'b1;
      if (state_dbg == ST_RECOVER) rec_cnt++;
    end
    check("abort cs_never", cs_seen, 1'b0);
    check("abort recover", rec_cnt, 1);
    check("abort idle", state_dbg, ST_IDLE);
    check("abort wait_n", bus.WAIT_N, 1'b1);
    release_and_idle("abort");

    // Reset during WAITST with WS=3.
    io_write(8'h98);
    start_cycle(5'b11000, 1'b0, 1'b0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk);
      #1;
      if (!bus.WAIT_N) found = 1'b1;
    end
    check("rstw wait_seen", found, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    bus_idle();
    @(posedge clk);
    #1;
    check("rstw wait_n", bus.WAIT_N, 1'b1);
    check("rstw cs_n", bus.RAM_CS_N, 1'b1);
    check("rstw ctrl", bus.CTRL, 8'h80);
    check("rstw state", state_dbg, ST_IDLE);
    check("rstw ba", bus.RAM_BA, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    rec_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (state_dbg != ST_IDLE) rec_cnt++;
    end
    check("rstw no_recover", rec_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
